// File: rtl/module_keypad_scanner_pkg.sv
// Shared types and key map for the 4x4 keypad scanner.
// KEYMAP is indexed [row][column].
package pkg_teclado;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DEBOUNCE,
      HELD
   } scan_state_t;

   localparam logic [3:0] KEY_A = 4'd10;
   localparam logic [3:0] KEY_B = 4'd11;

   localparam logic [3:0] KEYMAP [4][4] = '{
      '{4'd1,  4'd2, 4'd3,  KEY_A},
      '{4'd4,  4'd5, 4'd6,  KEY_B},
      '{4'd7,  4'd8, 4'd9,  4'd12},
      '{4'd14, 4'd0, 4'd15, 4'd13}
   };

endpackage

// File: rtl/module_keypad_scanner_sync2.sv
// Two-flop synchronizer for the asynchronous keypad row pins.
// The reset value matches the idle (pulled-up) pin level.
module module_sync2 #(
   parameter int              W       = 4,
   parameter logic [W-1:0]    RST_VAL = '1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] r_s1;
   logic [W-1:0] r_s2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s1 <= RST_VAL;
         r_s2 <= RST_VAL;
      end else begin
         r_s1 <= d;
         r_s2 <= r_s1;
      end
   end

   assign q = r_s2;

endmodule

// File: rtl/module_keypad_scanner.sv
// 4x4 keypad scan controller: column drive, row sampling,
// press/release debounce and one key_valid pulse per press.
module module_keypad_scanner
   import pkg_teclado::*;
#(
   parameter int SCAN_DIV     = 4,
   parameter int DEBOUNCE_CNT = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scan_en,
   input  logic [3:0] row,
   output logic [3:0] column,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam bit            ACC_NOW  = (DEBOUNCE_CNT == 1);

   scan_state_t     r_state;
   logic [1:0]      r_idx;
   logic [1:0]      r_r;
   logic [3:0]      r_pat;
   logic [DW-1:0]   r_div;
   logic [CW-1:0]   r_cnt;
   logic [3:0]      r_code;
   logic            r_valid;

   logic [3:0]      w_row_s;
   logic [3:0]      w_low;
   logic            w_one;
   logic            w_tick;
   logic [1:0]      w_ridx;
   logic [1:0]      w_kr;
   logic [3:0]      w_code;
   logic [CW-1:0]   w_cnt_inc;

   module_sync2 #(
      .W       (4),
      .RST_VAL (4'hF)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (row),
      .q   (w_row_s)
   );

   assign w_low     = ~w_row_s;
   assign w_one     = (w_low != 4'h0) && ((w_low & (w_low - 4'h1)) == 4'h0);
   assign w_tick    = (r_div == DIV_LAST);
   assign w_cnt_inc = r_cnt + 1'b1;

   always_comb begin
      w_ridx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (w_low[i]) w_ridx = 2'(i);
      end
   end

   // Immediate acceptance (DEBOUNCE_CNT==1) decodes the live row index.
   assign w_kr   = (r_state == SCAN) ? w_ridx : r_r;
   assign w_code = KEYMAP[w_kr][r_idx];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_idx   <= 2'd0;
         r_r     <= 2'd0;
         r_pat   <= 4'hF;
         r_div   <= '0;
         r_cnt   <= '0;
         r_code  <= 4'h0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (!scan_en) begin
            r_state <= IDLE;
            r_idx   <= 2'd0;
            r_div   <= '0;
            r_cnt   <= '0;
         end else if (r_state == IDLE) begin
            r_state <= SCAN;
            r_idx   <= 2'd0;
            r_div   <= '0;
            r_cnt   <= '0;
         end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) begin
               unique case (r_state)
                  SCAN: begin
                     if (w_one) begin
                        r_pat <= w_row_s;
                        r_r   <= w_ridx;
                        if (ACC_NOW) begin
                           r_valid <= 1'b1;
                           r_code  <= w_code;
                           r_state <= HELD;
                           r_cnt   <= '0;
                        end else begin
                           r_state <= DEBOUNCE;
                           r_cnt   <= CNT_ONE;
                        end
                     end else begin
                        r_idx <= r_idx + 1'b1;
                     end
                  end
                  DEBOUNCE: begin
                     if (w_row_s == r_pat) begin
                        if (w_cnt_inc == CNT_LAST) begin
                           r_valid <= 1'b1;
                           r_code  <= w_code;
                           r_state <= HELD;
                           r_cnt   <= '0;
                        end else begin
                           r_cnt <= w_cnt_inc;
                        end
                     end else begin
                        r_state <= SCAN;
                        r_idx   <= r_idx + 1'b1;
                        r_cnt   <= '0;
                     end
                  end
                  HELD: begin
                     if (w_row_s == 4'hF) begin
                        if (w_cnt_inc == CNT_LAST) begin
                           r_state <= SCAN;
                           r_idx   <= r_idx + 1'b1;
                           r_cnt   <= '0;
                        end else begin
                           r_cnt <= w_cnt_inc;
                        end
                     end else begin
                        r_cnt <= '0;
                     end
                  end
                  default: r_state <= IDLE;
               endcase
            end
         end
      end
   end

   assign column    = (r_state == IDLE) ? 4'hF : ~(4'b0001 << r_idx);
   assign key_code  = r_code;
   assign key_valid = r_valid;
   assign key_held  = (r_state == HELD);

endmodule

// File: tb/tb_module_keypad_scanner.sv
// Bench for module_keypad_scanner: slot-level keypad model and
// scenario tasks for scan, debounce, ghosting, reset and disable.
module tb_module_keypad_scanner;

   localparam int DB = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       scan_en;
   logic [3:0] row;
   logic [3:0] column;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   logic [15:0] keys;

   int errors   = 0;
   int checks   = 0;
   int n_pulses = 0;
   int codes[$];

   int          m_col;
   logic [3:0]  m_hist[$];
   bit          m_held;
   int          m_rel;
   logic [3:0]  m_code;

   string KEYCH = "123A456B789C*0#D";

   always #5 clk = ~clk;

   module_keypad_scanner #(
      .SCAN_DIV     (4),
      .DEBOUNCE_CNT (DB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .scan_en   (scan_en),
      .row       (row),
      .column    (column),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   // Physical matrix: a pressed key shorts its row to its driven column.
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !column[c]) row[r] = 1'b0;
   end

   always @(negedge clk) begin
      if (key_valid) begin
         n_pulses++;
         codes.push_back(int'(key_code));
      end
   end

   function automatic logic [3:0] code_of(int k);
      byte ch;
      ch = KEYCH[k];
      if (ch >= "0" && ch <= "9") return 4'(ch - "0");
      if (ch >= "A" && ch <= "D") return 4'(ch - "A" + 10);
      if (ch == "*") return 4'd14;
      return 4'd15;
   endfunction

   task automatic model_reset(bit full);
      m_col  = 0;
      m_hist.delete();
      m_held = 0;
      m_rel  = 0;
      if (full) m_code = 4'h0;
   endtask

   // One column slot: model decides from the sample, DUT runs 4 cycles.
   task automatic run_slot(output logic [9:0] o, output logic [9:0] e);
      logic [3:0] s;
      logic [3:0] col_o;
      logic [3:0] col_e;
      logic       acc;
      int         col;
      int         rr;
      col   = m_col;
      col_o = column;
      col_e = ~(4'b0001 << col);
      acc   = 1'b0;
      rr    = 0;
      for (int r = 0; r < 4; r++) s[r] = ~keys[r*4+col];
      if (m_held) begin
         if (s == 4'hF) m_rel++;
         else m_rel = 0;
         if (m_rel == DB) begin
            m_held = 0;
            m_col  = (m_col + 1) % 4;
         end
      end else if (m_hist.size() == 0) begin
         if ($countones(~s) == 1) m_hist.push_back(s);
         else m_col = (m_col + 1) % 4;
      end else if (s == m_hist[0]) begin
         m_hist.push_back(s);
         if (m_hist.size() == DB) begin
            for (int r = 0; r < 4; r++) if (!s[r]) rr = r;
            acc    = 1'b1;
            m_held = 1;
            m_rel  = 0;
            m_hist.delete();
            m_code = code_of(rr*4 + col);
         end
      end else begin
         m_hist.delete();
         m_col = (m_col + 1) % 4;
      end
      repeat (4) @(posedge clk);
      @(negedge clk);
      o = {col_o, key_valid, key_held, key_code};
      e = {col_e, acc, logic'(m_held), m_code};
   endtask

   task automatic start_scan();
      scan_en = 1'b1;
      model_reset(0);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [9:0] o, e;
      rst = 1'b0; scan_en = 1'b0; keys = '0;
      model_reset(1);
      repeat (3) @(negedge clk);
      checks++;
      if ({column, key_valid, key_held, key_code} !== 10'b1111_0_0_0000) begin
         errors++;
         $display("FAIL reset_vals got %b want %b",
                  {column, key_valid, key_held, key_code}, 10'b1111_0_0_0000);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (column !== 4'hF) begin
         errors++;
         $display("FAIL idle_col got %h want f", column);
      end
      start_scan();
      for (int i = 0; i < 10; i++) begin
         run_slot(o, e);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL scan_idle slot %0d got %b want %b", i, o, e);
         end
      end
      checks++;
      if (n_pulses !== 0) begin
         errors++;
         $display("FAIL scan_idle_pulses got %0d want 0", n_pulses);
      end
   endtask

   task automatic test_single_key();
      logic [9:0] o, e;
      int p0;
      p0 = n_pulses;
      keys = '0; keys[5] = 1'b1;
      for (int i = 0; i < 18; i++) begin
         if (i == 12) keys = '0;
         run_slot(o, e);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL key5 slot %0d got %b want %b", i, o, e);
         end
      end
      checks++;
      if (n_pulses - p0 !== 1 || key_code !== 4'd5 || key_held !== 1'b0) begin
         errors++;
         $display("FAIL key5_once pulses=%0d code=%0d held=%b want 1/5/0",
                  n_pulses - p0, key_code, key_held);
      end
   endtask

   task automatic test_bounce();
      logic [9:0] o, e;
      int p0, nsamp;
      p0 = n_pulses; nsamp = 0;
      for (int i = 0; i < 24; i++) begin
         keys = '0;
         keys[9] = (i < 20) && (nsamp != 1);
         if (m_col == 1 && !m_held) nsamp++;
         run_slot(o, e);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL bounce slot %0d got %b want %b", i, o, e);
         end
      end
      checks++;
      if (n_pulses - p0 !== 1 || key_code !== 4'd8) begin
         errors++;
         $display("FAIL bounce_once pulses=%0d code=%0d want 1/8",
                  n_pulses - p0, key_code);
      end
      p0 = n_pulses; nsamp = 0;
      for (int i = 0; i < 14; i++) begin
         keys = '0;
         keys[9] = (nsamp < 2);
         if (m_col == 1) nsamp++;
         run_slot(o, e);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL short slot %0d got %b want %b", i, o, e);
         end
      end
      checks++;
      if (n_pulses - p0 !== 0) begin
         errors++;
         $display("FAIL short_press pulses=%0d want 0", n_pulses - p0);
      end
   endtask

   task automatic test_ghost();
      logic [9:0] o, e;
      int p0;
      p0 = n_pulses;
      keys = '0; keys[0] = 1'b1; keys[4] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         run_slot(o, e);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL ghost slot %0d got %b want %b", i, o, e);
         end
      end
      keys = '0;
      checks++;
      if (n_pulses - p0 !== 0) begin
         errors++;
         $display("FAIL ghost_pulses got %0d want 0", n_pulses - p0);
      end
   endtask

   task automatic test_back_to_back();
      logic [9:0] o, e;
      int seq[3] = '{3, 14, 3};
      int c0;
      c0 = codes.size();
      for (int k = 0; k < 3; k++) begin
         keys = '0; keys[seq[k]] = 1'b1;
         for (int i = 0; i < 12 && !m_held; i++) begin
            run_slot(o, e);
            checks++;
            if (o !== e) begin
               errors++;
               $display("FAIL seq%0d press slot %0d got %b want %b", k, i, o, e);
            end
         end
         keys = '0;
         for (int i = 0; i < 8 && m_held; i++) begin
            run_slot(o, e);
            checks++;
            if (o !== e) begin
               errors++;
               $display("FAIL seq%0d rel slot %0d got %b want %b", k, i, o, e);
            end
         end
      end
      checks++;
      if (codes.size() - c0 !== 3) begin
         errors++;
         $display("FAIL seq_count got %0d want 3", codes.size() - c0);
      end else if (codes[c0] !== 10 || codes[c0+1] !== 15 || codes[c0+2] !== 10) begin
         errors++;
         $display("FAIL seq_codes got %0d,%0d,%0d want 10,15,10",
                  codes[c0], codes[c0+1], codes[c0+2]);
      end
   endtask

   task automatic test_random();
      logic [9:0] o, e;
      for (int i = 0; i < 160; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            keys = '0;
            case ($urandom_range(0, 2))
               1: keys[$urandom_range(0, 15)] = 1'b1;
               2: begin
                  keys[$urandom_range(0, 15)] = 1'b1;
                  keys[$urandom_range(0, 15)] = 1'b1;
               end
               default: keys = '0;
            endcase
         end
         run_slot(o, e);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL rand slot %0d got %b want %b", i, o, e);
         end
      end
      keys = '0;
   endtask

   task automatic test_reset_held();
      logic [9:0] o, e;
      keys = '0; keys[5] = 1'b1;
      for (int i = 0; i < 12 && !m_held; i++) run_slot(o, e);
      checks++;
      if (!m_held || key_held !== 1'b1) begin
         errors++;
         $display("FAIL rst_held_setup held=%b want 1", key_held);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({column, key_held, key_code} !== 9'b1111_0_0000) begin
         errors++;
         $display("FAIL rst_held got %b want %b",
                  {column, key_held, key_code}, 9'b1111_0_0000);
      end
      keys = '0; scan_en = 1'b0;
      model_reset(1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      start_scan();
      for (int i = 0; i < 4; i++) begin
         run_slot(o, e);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL post_rst slot %0d got %b want %b", i, o, e);
         end
      end
   endtask

   task automatic test_disable_debounce();
      logic [9:0] o, e;
      int p0;
      keys = '0; keys[5] = 1'b1;
      for (int i = 0; i < 8 && m_hist.size() == 0; i++) run_slot(o, e);
      checks++;
      if (m_hist.size() != 1) begin
         errors++;
         $display("FAIL dis_setup hist=%0d want 1", m_hist.size());
      end
      p0 = n_pulses;
      scan_en = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({column, key_held} !== 5'b1111_0) begin
         errors++;
         $display("FAIL dis_idle got %b want 11110", {column, key_held});
      end
      repeat (8) @(negedge clk);
      checks++;
      if (n_pulses - p0 !== 0 || column !== 4'hF) begin
         errors++;
         $display("FAIL dis_nopulse pulses=%0d col=%h want 0/f",
                  n_pulses - p0, column);
      end
      keys = '0;
      start_scan();
      for (int i = 0; i < 6; i++) begin
         run_slot(o, e);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL dis_resume slot %0d got %b want %b", i, o, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_key();
      test_bounce();
      test_ghost();
      test_back_to_back();
      test_random();
      test_reset_held();
      test_disable_debounce();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

endmodule
